// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (divide by 2..2^W-1) with pulse, square
// and symmetric-50% output shapes; new settings take effect only at a period boundary.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int unsigned W            = 8,
  parameter int unsigned DEFAULT_DIV  = 7,
  parameter logic [1:0]  DEFAULT_MODE = 2'd2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] cfg_div,
  input  logic [1:0]   cfg_mode,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         tick,
  output logic         active
);

  // Config handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready is low exactly while a legal config is waiting for its boundary, so a
  // second offer is held off by the source rather than dropped.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [1:0] MODE_PULSE = 2'd0;
  localparam logic [1:0] MODE_SYM   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_cur_q, div_cur_d;
  logic [1:0]   mode_cur_q, mode_cur_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic [1:0]   pend_mode_q, pend_mode_d;
  logic         pos_q, pos_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;
  logic         sym_neg_q;

  logic accept, legal, last, apply, sym_odd;

  // High/low level of the rising-edge half of clk_out for cycle k of an N-cycle period.
  // Halves are computed W+1 wide so N = 2^W-1 cannot overflow.
  function automatic logic shape_hi(input logic [W-1:0] k, input logic [W-1:0] n,
                                    input logic [1:0] m);
    logic [W:0] half_up;
    logic [W:0] half_dn;
    logic [W:0] kx;
    half_up = ({1'b0, n} + {{W{1'b0}}, 1'b1}) >> 1;
    half_dn = {1'b0, n} >> 1;
    kx      = {1'b0, k};
    case (m)
      MODE_PULSE: shape_hi = (k == '0);
      MODE_SYM:   shape_hi = n[0] ? (kx < half_dn) : (kx < half_up);
      default:    shape_hi = (kx < half_up);
    endcase
  endfunction

  assign accept = cfg_valid && !pend_q;
  assign legal  = (cfg_div >= W'(2)) && (cfg_mode != MODE_RSVD);
  assign last   = (cnt_q == div_cur_q - W'(1));
  assign apply  = pend_q && ((state_q == S_IDLE) || last);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_cur_d   = div_cur_q;
    mode_cur_d  = mode_cur_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    pos_d       = 1'b0;
    tick_d      = 1'b0;
    err_d       = 1'b0;

    if (apply) begin
      div_cur_d  = pend_div_q;
      mode_cur_d = pend_mode_q;
      pend_d     = 1'b0;
    end

    // accept implies !pend_q, so it never collides with apply in the same cycle
    if (accept) begin
      if (legal) begin
        pend_d      = 1'b1;
        pend_div_d  = cfg_div;
        pend_mode_d = cfg_mode;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          cnt_d   = '0;
          tick_d  = 1'b1;
          pos_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (!last) begin
          cnt_d = cnt_q + W'(1);
          pos_d = shape_hi(cnt_q + W'(1), div_cur_q, mode_cur_q);
        end else if (en) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          pos_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_cur_q   <= W'(DEFAULT_DIV);
      mode_cur_q  <= DEFAULT_MODE;
      pend_q      <= 1'b0;
      pend_div_q  <= W'(DEFAULT_DIV);
      pend_mode_q <= DEFAULT_MODE;
      pos_q       <= 1'b0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_cur_q   <= div_cur_d;
      mode_cur_q  <= mode_cur_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pos_q       <= pos_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end

  // Odd N in symmetric mode: a half-cycle-delayed copy stretches the high phase by
  // exactly half an input period.
  assign sym_odd = (state_q == S_RUN) && (mode_cur_q == MODE_SYM) && div_cur_q[0];

  always_ff @(negedge clk_in) begin
    if (rst) begin
      sym_neg_q <= 1'b0;
    end else begin
      sym_neg_q <= sym_odd && pos_q;
    end
  end

  assign cfg_ready = !pend_q;
  assign cfg_err   = err_q;
  assign clk_out   = pos_q | sym_neg_q;
  assign tick      = tick_q;
  assign active    = (state_q == S_RUN);

endmodule
